frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 390: first 3D-region column (VGA hcount).
REQ-002 SHALL have parameter START_Y, default 390: first 3D-region row (VGA vcount).
REQ-003 SHALL have parameter REGION_W, default 244: region width in pixels.
REQ-004 SHALL have parameter REGION_H, default 375: region height in pixels.
REQ-005 SHALL have parameter REGION_DIVIDE, default 530: rows below this use TOP_SHIFT.
REQ-006 SHALL have parameter TOP_SHIFT, default 2: write-column correction for rows < REGION_DIVIDE.
REQ-007 SHALL have parameter DOUBLE_BUFFER, default 1: 1 = ping-pong banks, 0 = single bank.
REQ-008 SHALL have parameter RD_LATENCY, default 2, legal range 2..4: read pipeline depth in cycles.
REQ-009 clk_in  input  1  pixel clock; the only clock.
REQ-010 rst_in  input  1  asynchronous, active-high reset.
REQ-011 wr_hcount_in  input  11  renderer output column.
REQ-012 wr_vcount_in  input  10  renderer output row.
REQ-013 wr_pixel_in  input  24  RGB888 pixel.
REQ-014 wr_valid_in  input  1  pixel valid.
REQ-015 wr_ready_out  output  1  write accepted when valid and ready.
REQ-016 rd_hcount_in, rd_vcount_in  input  11/10  VGA scan position.
REQ-017 rd_hsync_in, rd_vsync_in, rd_active_in  input  1 each  VGA timing.
REQ-018 rd_new_frame_in  input  1  one-cycle pulse at VGA frame start.
REQ-019 red_out, green_out, blue_out  output  4 each  displayed pixel.
REQ-020 hsync_out, vsync_out  output  1 each  timing delayed to match pixel.
REQ-021 front_buf_out  output  1  bank currently displayed.
REQ-022 frame_done_out  output  1  one-cycle pulse when back bank is fully written.

Function
REQ-023 Write FSM SHALL have states IDLE, FILL, FULL; IDLE->FILL on accepted write at (START_X+shift, START_Y); FILL->FULL on accepted write at last column and row START_Y+REGION_H-1; FULL->IDLE on rd_new_frame_in.
REQ-024 wr_ready_out SHALL be 1 in IDLE/FILL, 0 in FULL; when DOUBLE_BUFFER=0 it SHALL always be 1 and FULL SHALL return to IDLE the next cycle.
REQ-025 Stored pixel SHALL be {R[23:20],G[15:12],B[7:4]} (12 bits).
REQ-026 Write address SHALL be (h-START_X-s)+(v-START_Y)*REGION_W + back_bank*REGION_W*REGION_H, s=TOP_SHIFT if v<REGION_DIVIDE else 0; writes outside the region after shift SHALL be dropped.
REQ-027 On FULL->IDLE, front_buf_out SHALL toggle in the same edge (DOUBLE_BUFFER=1); back bank = ~front.
REQ-028 If the last write and rd_new_frame_in coincide, no swap SHALL occur; swap waits for the next pulse.
REQ-029 frame_done_out SHALL pulse on the cycle after entering FULL.
REQ-030 RGB outputs SHALL be valid exactly RD_LATENCY cycles after rd_* inputs; outside region or rd_active_in=0, outputs SHALL be 0.
REQ-031 hsync_out/vsync_out SHALL be rd_hsync_in/rd_vsync_in delayed RD_LATENCY cycles.
REQ-032 Address width SHALL be $clog2(2*REGION_W*REGION_H); multiply by REGION_W SHALL not truncate.

Reset
REQ-033 Reset SHALL force IDLE, front_buf_out=0, frame_done_out=0, RGB/sync outputs 0, pipelines cleared; wr_ready_out=1 after release.
REQ-034 Reset mid-FILL SHALL abandon the frame; memory contents SHALL NOT be cleared.

Structure
REQ-035 Shared package SHALL hold the FSM state enum and the RGB888->RGB444 packing function.
REQ-036 Storage SHALL be one sub-module fb_bank_ram (1 write, 1 read port, registered read).

Verification (bench params REGION_W=8, REGION_H=4, START_X=10, START_Y=20, REGION_DIVIDE=0)
REQ-037 Assert rst_in mid-stream -> all outputs 0, front_buf_out=0, wr_ready_out=1 after release.
REQ-038 32 writes of 24'hF0A050 -> frame_done_out pulse, wr_ready_out=0; rd_new_frame_in -> front_buf_out=1; read (10,20) -> R=F,G=A,B=5 two cycles later.
REQ-039 Read (9,20) or rd_active_in=0 -> RGB 0; hsync toggle appears on hsync_out exactly 2 cycles later.
REQ-040 wr_valid_in with 24'h00FF00 while FULL -> no write; after swap, old bank content unchanged.
REQ-041 Last write coincident with rd_new_frame_in -> front_buf_out unchanged; toggles on next pulse.
REQ-042 REGION_DIVIDE=22, TOP_SHIFT=2: write 24'h123456 at (12,20) -> read (10,20) returns 1,3,5.

Source files
------------

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and helpers for the frame buffer controller: write-FSM
// state encoding and RGB888 -> RGB444 packing.
package frame_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } fb_state_t;

  localparam int PIX_W = 12;

  // Keep the top nibble of each colour channel; the low nibbles are discarded.
  function automatic logic [PIX_W-1:0] pack_rgb444(input logic [23:0] rgb);
    logic [11:0] unused_low_nibbles;
    unused_low_nibbles = {rgb[19:16], rgb[11:8], rgb[3:0]};
    return {rgb[23:20], rgb[15:12], rgb[7:4]};
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_bank_ram.sv
// Simple dual-port pixel store: one write port, one read port with a
// registered read (read-before-write on an address collision).
module fb_bank_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_in,
  input  logic          wr_en_in,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [DW-1:0] wr_data_in,
  input  logic [AW-1:0] rd_addr_in,
  output logic [DW-1:0] rd_data_out
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Storage write and registered read; contents are never reset.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) r_mem[wr_addr_in] <= wr_data_in;
    r_rd_data <= r_mem[rd_addr_in];
  end

  assign rd_data_out = r_rd_data;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: captures a renderer's pixels for a fixed screen
// region into a back bank, swaps banks at VGA frame start once a frame is
// complete, and scans the front bank out with a fixed read latency.
//
// Write handshake: a pixel transfers on a rising clk_in edge where both
// wr_valid_in and wr_ready_out are 1; wr_ready_out does not depend on
// wr_valid_in, and pixels offered while wr_ready_out is 0 are ignored.
module frame_buffer_ctrl #(
  parameter int START_X       = 390,
  parameter int START_Y       = 390,
  parameter int REGION_W      = 244,
  parameter int REGION_H      = 375,
  parameter int REGION_DIVIDE = 530,
  parameter int TOP_SHIFT     = 2,
  parameter int DOUBLE_BUFFER = 1,
  parameter int RD_LATENCY    = 2    // legal 2..4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] wr_hcount_in,
  input  logic [9:0]  wr_vcount_in,
  input  logic [23:0] wr_pixel_in,
  input  logic        wr_valid_in,
  output logic        wr_ready_out,
  input  logic [10:0] rd_hcount_in,
  input  logic [9:0]  rd_vcount_in,
  input  logic        rd_hsync_in,
  input  logic        rd_vsync_in,
  input  logic        rd_active_in,
  input  logic        rd_new_frame_in,
  output logic [3:0]  red_out,
  output logic [3:0]  green_out,
  output logic [3:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        front_buf_out,
  output logic        frame_done_out,
  output logic [1:0]  dbg_state_out
);
  import frame_buffer_ctrl_pkg::*;

  localparam int FRAME_PIX = REGION_W * REGION_H;
  localparam int AW        = $clog2(2 * FRAME_PIX);

  fb_state_t        r_state, w_next;
  logic             r_front, r_frame_done, r_rd_en_d1;
  logic [PIX_W-1:0] r_pix_pipe [RD_LATENCY-1];
  logic [1:0]       r_sync_pipe [RD_LATENCY];

  logic [31:0]      w_wr_shift, w_wr_col, w_wr_row, w_rd_col, w_rd_row;
  logic             w_wr_in_region, w_wr_first, w_wr_last, w_wr_accept, w_wr_en;
  logic             w_wr_bank, w_rd_en, w_enter_full, w_swap;
  logic [AW-1:0]    w_wr_addr, w_rd_addr;
  logic [PIX_W-1:0] w_ram_q;

  // Write-side address math in 32 bits so the row multiply never truncates.
  always_comb begin
    w_wr_bank      = (DOUBLE_BUFFER != 0) ? ~r_front : 1'b0;
    w_wr_shift     = (32'(wr_vcount_in) < 32'(REGION_DIVIDE)) ? 32'(TOP_SHIFT) : 32'd0;
    w_wr_col       = 32'(wr_hcount_in) - 32'(START_X) - w_wr_shift;
    w_wr_row       = 32'(wr_vcount_in) - 32'(START_Y);
    w_wr_in_region = (32'(wr_hcount_in) >= 32'(START_X) + w_wr_shift) &&
                     (w_wr_col < 32'(REGION_W)) &&
                     (32'(wr_vcount_in) >= 32'(START_Y)) &&
                     (w_wr_row < 32'(REGION_H));
    w_wr_first     = w_wr_in_region && (w_wr_col == 32'd0) && (w_wr_row == 32'd0);
    w_wr_last      = w_wr_in_region && (w_wr_col == 32'(REGION_W - 1)) &&
                     (w_wr_row == 32'(REGION_H - 1));
    w_wr_accept    = wr_valid_in && wr_ready_out;
    w_wr_en        = w_wr_accept && w_wr_in_region;
    w_wr_addr      = AW'(w_wr_col + w_wr_row * 32'(REGION_W) +
                         (w_wr_bank ? 32'(FRAME_PIX) : 32'd0));
  end

  // Read-side address math: the front bank is always the one scanned out.
  always_comb begin
    w_rd_col  = 32'(rd_hcount_in) - 32'(START_X);
    w_rd_row  = 32'(rd_vcount_in) - 32'(START_Y);
    w_rd_en   = rd_active_in &&
                (32'(rd_hcount_in) >= 32'(START_X)) && (w_rd_col < 32'(REGION_W)) &&
                (32'(rd_vcount_in) >= 32'(START_Y)) && (w_rd_row < 32'(REGION_H));
    w_rd_addr = AW'(w_rd_col + w_rd_row * 32'(REGION_W) +
                    (r_front ? 32'(FRAME_PIX) : 32'd0));
  end

  // Write FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Write FSM next state: a frame starts at its first pixel and completes at
  // its last; a full frame waits for a VGA frame start (single bank: no wait).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_wr_accept && w_wr_first) w_next = ST_FILL;
      ST_FILL: if (w_wr_accept && w_wr_last)  w_next = ST_FULL;
      ST_FULL: begin
        if (DOUBLE_BUFFER == 0)   w_next = (w_wr_accept && w_wr_first) ? ST_FILL : ST_IDLE;
        else if (rd_new_frame_in) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Write FSM outputs: back-pressure only while a finished frame awaits a swap.
  always_comb begin
    wr_ready_out = (r_state != ST_FULL) || (DOUBLE_BUFFER == 0);
    w_enter_full = (r_state == ST_FILL) && (w_next == ST_FULL);
    w_swap       = (r_state == ST_FULL) && (w_next == ST_IDLE) && (DOUBLE_BUFFER != 0);
  end

  // Front-bank select and frame-complete pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_front      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_enter_full;
      if (w_swap) r_front <= ~r_front;
    end
  end

  fb_bank_ram #(
    .DW    (PIX_W),
    .DEPTH (2 * FRAME_PIX),
    .AW    (AW)
  ) u_ram (
    .clk_in      (clk_in),
    .wr_en_in    (w_wr_en),
    .wr_addr_in  (w_wr_addr),
    .wr_data_in  (pack_rgb444(wr_pixel_in)),
    .rd_addr_in  (w_rd_addr),
    .rd_data_out (w_ram_q)
  );

  // Read pipeline: RAM register plus RD_LATENCY-1 output stages; syncs are
  // delayed by the same number of cycles so they stay aligned with pixels.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_en_d1 <= 1'b0;
      for (int i = 0; i < RD_LATENCY - 1; i++) r_pix_pipe[i] <= '0;
      for (int i = 0; i < RD_LATENCY; i++)     r_sync_pipe[i] <= '0;
    end else begin
      r_rd_en_d1    <= w_rd_en;
      r_pix_pipe[0] <= r_rd_en_d1 ? w_ram_q : '0;
      for (int i = 1; i < RD_LATENCY - 1; i++) r_pix_pipe[i] <= r_pix_pipe[i-1];
      r_sync_pipe[0] <= {rd_hsync_in, rd_vsync_in};
      for (int i = 1; i < RD_LATENCY; i++)     r_sync_pipe[i] <= r_sync_pipe[i-1];
    end
  end

  assign {red_out, green_out, blue_out} = r_pix_pipe[RD_LATENCY-2];
  assign {hsync_out, vsync_out}         = r_sync_pipe[RD_LATENCY-1];
  assign front_buf_out                  = r_front;
  assign frame_done_out                 = r_frame_done;
  assign dbg_state_out                  = r_state;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: randomized frames and scan positions checked
// every cycle against a behavioural model of the two pixel banks.
module tb_frame_buffer_ctrl;

  localparam int SX = 10, SY = 20, W = 8, H = 4, FP = W * H;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] wr_h, rd_h, w2_h;
  logic [9:0]  wr_v, rd_v, w2_v;
  logic [23:0] wr_pix, w2_pix;
  logic        wr_valid, wr_ready, w2_valid, w2_ready;
  logic        rd_hs, rd_vs, rd_act, rd_nf;
  logic [3:0]  red, green, blue, red2, green2, blue2;
  logic        hs_o, vs_o, front, done, hs2, vs2, front2, done2;
  logic [1:0]  dbg, dbg2;

  always #5 clk = ~clk;

  frame_buffer_ctrl #(
    .START_X(SX), .START_Y(SY), .REGION_W(W), .REGION_H(H),
    .REGION_DIVIDE(0), .TOP_SHIFT(2), .DOUBLE_BUFFER(1), .RD_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .wr_hcount_in(wr_h), .wr_vcount_in(wr_v), .wr_pixel_in(wr_pix),
    .wr_valid_in(wr_valid), .wr_ready_out(wr_ready),
    .rd_hcount_in(rd_h), .rd_vcount_in(rd_v), .rd_hsync_in(rd_hs),
    .rd_vsync_in(rd_vs), .rd_active_in(rd_act), .rd_new_frame_in(rd_nf),
    .red_out(red), .green_out(green), .blue_out(blue),
    .hsync_out(hs_o), .vsync_out(vs_o), .front_buf_out(front),
    .frame_done_out(done), .dbg_state_out(dbg)
  );

  // Second instance: single bank with a top-row column shift.
  frame_buffer_ctrl #(
    .START_X(SX), .START_Y(SY), .REGION_W(W), .REGION_H(H),
    .REGION_DIVIDE(22), .TOP_SHIFT(2), .DOUBLE_BUFFER(0), .RD_LATENCY(2)
  ) dut2 (
    .clk_in(clk), .rst_in(rst),
    .wr_hcount_in(w2_h), .wr_vcount_in(w2_v), .wr_pixel_in(w2_pix),
    .wr_valid_in(w2_valid), .wr_ready_out(w2_ready),
    .rd_hcount_in(rd_h), .rd_vcount_in(rd_v), .rd_hsync_in(rd_hs),
    .rd_vsync_in(rd_vs), .rd_active_in(rd_act), .rd_new_frame_in(rd_nf),
    .red_out(red2), .green_out(green2), .blue_out(blue2),
    .hsync_out(hs2), .vsync_out(vs2), .front_buf_out(front2),
    .frame_done_out(done2), .dbg_state_out(dbg2)
  );

  // ---------------- reference model ----------------
  logic [11:0] m_mem [2][FP];
  bit          m_wr  [2][FP];
  bit          m_front, m_full, m_filling;
  // {check_rgb, hsync, vsync, rgb444} expected two edges after sampling
  logic [14:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to444(input logic [23:0] p);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction

  function automatic logic [14:0] read_expect();
    int col, row, idx;
    col = int'(rd_h) - SX;
    row = int'(rd_v) - SY;
    if (!rd_act || col < 0 || col >= W || row < 0 || row >= H)
      return {1'b1, rd_hs, rd_vs, 12'h000};
    idx = row * W + col;
    return {m_wr[m_front][idx], rd_hs, rd_vs, m_mem[m_front][idx]};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock edge: update the model from the sampled inputs, then compare.
  task automatic step();
    logic [14:0] e_new, e_cur;
    bit acc, inreg, done_exp;
    int col, row;
    @(posedge clk);
    e_new    = read_expect();
    done_exp = 0;
    acc      = wr_valid && !m_full;
    col      = int'(wr_h) - SX;
    row      = int'(wr_v) - SY;
    inreg    = col >= 0 && col < W && row >= 0 && row < H;
    if (acc && inreg) begin
      m_mem[!m_front][row * W + col] = to444(wr_pix);
      m_wr[!m_front][row * W + col]  = 1;
    end
    if (m_full) begin
      if (rd_nf) begin
        m_full  = 0;
        m_front = !m_front;
      end
    end else if (acc && inreg && m_filling && col == W - 1 && row == H - 1) begin
      m_full    = 1;
      m_filling = 0;
      done_exp  = 1;
    end else if (acc && inreg && col == 0 && row == 0) begin
      m_filling = 1;
    end
    exp_q.push_back(e_new);
    #1;
    e_cur = exp_q.pop_front();
    check_eq("hsync_out", hs_o, e_cur[13]);
    check_eq("vsync_out", vs_o, e_cur[12]);
    if (e_cur[14]) check_eq("rgb_out", {red, green, blue}, e_cur[11:0]);
    check_eq("frame_done_out", done, done_exp);
    check_eq("wr_ready_out", wr_ready, !m_full);
    check_eq("front_buf_out", front, m_front);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("reset rgb", {red, green, blue}, 0);
    check_eq("reset hsync", hs_o, 0);
    check_eq("reset vsync", vs_o, 0);
    check_eq("reset front", front, 0);
    check_eq("reset frame_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_front = 0; m_full = 0; m_filling = 0;
    exp_q.delete();
    exp_q.push_back(15'h4000);
    #1;
    check_eq("ready after reset", wr_ready, 1);
  endtask

  task automatic rand_rd();
    rd_h   = 11'(SX - 2 + $urandom_range(0, W + 3));
    rd_v   = 10'(SY - 1 + $urandom_range(0, H + 1));
    rd_act = ($urandom_range(0, 3) != 0);
    rd_hs  = 1'($urandom_range(0, 1));
    rd_vs  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rand_rd();
      step();
    end
  endtask

  // Raster-order frame with random gaps and stray out-of-region writes.
  task automatic fill_frame(input bit fixed, input logic [23:0] fpix, input bit coincide, input int stop_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int gap;
        if (r * W + c >= stop_at) return;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'($urandom_range(0, 1));
          wr_h     = 11'(SX + W + $urandom_range(0, 5));
          wr_v     = 10'(SY + $urandom_range(0, H - 1));
          wr_pix   = 24'($urandom);
          rand_rd();
          step();
        end
        wr_valid = 1'b1;
        wr_h     = 11'(SX + c);
        wr_v     = 10'(SY + r);
        wr_pix   = fixed ? fpix : 24'($urandom);
        rd_nf    = coincide && (r == H - 1) && (c == W - 1);
        rand_rd();
        step();
        wr_valid = 1'b0;
        rd_nf    = 1'b0;
      end
    end
  endtask

  task automatic pulse_new_frame();
    rd_nf = 1'b1;
    rand_rd();
    step();
    rd_nf = 1'b0;
  endtask

  task automatic read_at(input int h, input int v, input bit act);
    rd_h = 11'(h); rd_v = 10'(v); rd_act = act; rd_hs = 0; rd_vs = 0;
    step();
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < FP; i++) begin m_mem[b][i] = '0; m_wr[b][i] = 0; end
    rst = 0; wr_h = 0; wr_v = 0; wr_pix = 0; wr_valid = 0;
    w2_h = 0; w2_v = 0; w2_pix = 0; w2_valid = 0;
    rd_h = 0; rd_v = 0; rd_hs = 0; rd_vs = 0; rd_act = 0; rd_nf = 0;
    #1;
    do_reset();
    idle_cycles(4);

    // Frame A: constant colour into bank 1.
    fill_frame(1, 24'hF0A050, 0, FP);
    check_eq("ready low when full", wr_ready, 0);
    // Pixels offered while full must be dropped.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_h = 11'(SX + ((i == 0) ? 0 : $urandom_range(0, W - 1)));
      wr_v = 10'(SY); wr_pix = 24'h00FF00; rand_rd(); step();
    end
    wr_valid = 0;
    pulse_new_frame();
    check_eq("front after swap", front, 1);
    read_at(SX, SY, 1);
    check_eq("read (10,20) R", red, 4'hF);
    check_eq("read (10,20) G", green, 4'hA);
    check_eq("read (10,20) B", blue, 4'h5);
    read_at(SX - 1, SY, 1);
    check_eq("read (9,20) rgb", {red, green, blue}, 0);
    read_at(SX, SY, 0);
    check_eq("inactive rgb", {red, green, blue}, 0);
    rd_hs = 1; step();
    check_eq("hsync +1 cycle", hs_o, 0);
    rd_hs = 0; step();
    check_eq("hsync +2 cycles", hs_o, 1);
    step();
    check_eq("hsync +3 cycles", hs_o, 0);
    idle_cycles(40);

    // Frame B: random pixels into bank 0, last write coincides with frame start.
    fill_frame(0, 24'h0, 1, FP);
    check_eq("front after coincident pulse", front, 1);
    idle_cycles(3);
    pulse_new_frame();
    check_eq("front after next pulse", front, 0);
    idle_cycles(40);

    // Frame C abandoned by reset part way through.
    fill_frame(0, 24'h0, 0, 10);
    wr_valid = 0;
    do_reset();
    idle_cycles(30);

    // Frame D after reset completes normally.
    fill_frame(0, 24'h0, 0, FP);
    idle_cycles(2);
    pulse_new_frame();
    idle_cycles(40);

    // Single-bank instance with top-row shift.
    w2_valid = 1; w2_h = 12; w2_v = 20; w2_pix = 24'h123456; rand_rd(); step();
    check_eq("dut2 ready", w2_ready, 1);
    w2_h = 12; w2_v = 21; w2_pix = 24'h111111; rand_rd(); step();
    w2_h = 10; w2_v = 21; w2_pix = 24'h777777; rand_rd(); step();
    w2_h = 10; w2_v = 22; w2_pix = 24'hABCDEF; rand_rd(); step();
    check_eq("dut2 ready stays high", w2_ready, 1);
    w2_valid = 0;
    read_at(10, 20, 1);
    check_eq("dut2 shifted (12,20)", {red2, green2, blue2}, 12'h135);
    read_at(10, 21, 1);
    check_eq("dut2 drop (10,21)", {red2, green2, blue2}, 12'h111);
    read_at(10, 22, 1);
    check_eq("dut2 unshifted (10,22)", {red2, green2, blue2}, 12'hACE);
    check_eq("dut2 front", front2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
